// File: rtl/glb_arb_pkg.sv
// Shared types and constants for the GLB port arbiter.
// Defines the stream ids and the read-response tag.
package glb_arb_pkg;

    typedef enum logic [1:0] {STR_IFMAP, STR_FILTER, STR_IPSUM, STR_OPSUM} stream_e;

    localparam int NUM_STREAMS    = 4;
    localparam int NUM_RD_STREAMS = 3;

    typedef struct packed {
        logic    v;
        stream_e id;
    } rsp_tag_t;

endpackage

// File: rtl/glb_port_arbiter_rr.sv
// Generic combinational round-robin arbiter.
// It grants the first requester found at or after ptr, searching upward with wraparound.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    logic                 found;
    logic [$clog2(N)-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            idx = $clog2(N)'((int'(ptr) + off) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/glb_port_arbiter.sv
// Arbitrates four processing-unit streams onto one single-port GLB SRAM.
// Read data returns to the requesting stream in grant order.
module glb_port_arbiter
    import glb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cfg_wr_prio,
    input  logic [NUM_STREAMS-1:0]            req_valid,
    output logic [NUM_STREAMS-1:0]            req_ready,
    input  logic [NUM_STREAMS*ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic [NUM_RD_STREAMS-1:0]         rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              sram_en,
    output logic                              sram_we,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    output logic [DATA_WIDTH-1:0]             sram_wdata,
    input  logic [DATA_WIDTH-1:0]             sram_rdata,
    input  logic                              clear_stats,
    output logic [NUM_STREAMS*CNT_WIDTH-1:0]  grant_cnt
);

    logic [NUM_STREAMS-1:0] rr_gnt;
    logic [NUM_STREAMS-1:0] gnt;
    logic [1:0]             ptr;
    logic [1:0]             gnt_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    rsp_tag_t               tag_q [READ_LATENCY+1];
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_STREAMS];

    rr_arbiter #(.N(NUM_STREAMS)) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (rr_gnt)
    );

    // Requests seen while reset is asserted must not handshake.
    always_comb begin
        if (reset)
            gnt = '0;
        else if (cfg_wr_prio && req_valid[3])
            gnt = 4'b1000;
        else
            gnt = rr_gnt;
    end

    assign req_ready = gnt;

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (gnt[i]) begin
                gnt_idx  = 2'(i);
                sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_en <= |gnt;
            sram_we <= gnt[3];
            if (|gnt) begin
                ptr        <= gnt_idx + 2'd1;
                sram_addr  <= sel_addr;
                sram_wdata <= wr_data;
            end
        end
    end

    // Stage 0 lines up with the SRAM command; stage READ_LATENCY lines up with sram_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= READ_LATENCY; k++)
                tag_q[k] <= '0;
        end else begin
            tag_q[0].v  <= (|gnt) && !gnt[3];
            tag_q[0].id <= stream_e'(gnt_idx);
            for (int k = 1; k <= READ_LATENCY; k++)
                tag_q[k] <= tag_q[k-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_q[READ_LATENCY].v) begin
            rsp_data = sram_rdata;
            for (int i = 0; i < NUM_RD_STREAMS; i++)
                rsp_valid[i] = (int'(tag_q[READ_LATENCY].id) == i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STREAMS; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                if (clear_stats)
                    cnt_q[i] <= '0;
                else if (gnt[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_cnt_out
        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end

endmodule

// File: tb/tb_glb_port_arbiter.sv
// Scoreboard bench for glb_port_arbiter with a behavioural SRAM of READ_LATENCY=2.
// Stimulus pushes expected grants, commands and responses; a monitor pops and compares.
module tb_glb_port_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int RL = 2;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_wr_prio = 1'b0;
    logic [3:0]      req_valid = '0;
    logic [3:0]      req_ready;
    logic [4*AW-1:0] req_addr;
    logic [DW-1:0]   wr_data = '0;
    logic [2:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            sram_en, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata, sram_rdata;
    logic            clear_stats = 1'b0;
    logic [4*CW-1:0] grant_cnt;

    logic [AW-1:0]   addr_of [4];
    assign req_addr = {addr_of[3], addr_of[2], addr_of[1], addr_of[0]};

    glb_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .cfg_wr_prio(cfg_wr_prio),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .wr_data(wr_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .clear_stats(clear_stats), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] = sram_wdata;
        rd_pipe[0] <= (sram_en && !sram_we && mem.exists(sram_addr)) ? mem[sram_addr] : 16'hDEAD;
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_rdata = rd_pipe[RL-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    int   gq[$];
    exp_t cq[$];
    exp_t rq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got 0x%0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // One cycle of stimulus; g is the hand-computed grant (-1 for none), d the read data expected back.
    task automatic step(input logic [3:0] v, input int g, input logic [DW-1:0] d, input bit want_rsp = 1'b1);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        if (g >= 0) begin
            gq.push_back(g);
            e.id   = g;
            e.we   = (g == 3);
            e.addr = addr_of[g];
            e.data = (g == 3) ? wr_data : d;
            e.due  = cyc + 1;
            cq.push_back(e);
            if (g < 3 && want_rsp) begin
                e.due = cyc + 1 + RL;
                rq.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        clear_stats = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (RL + 4) @(negedge clk);
        #3;
        chk("queues_empty", 64'(gq.size() + cq.size() + rq.size()), 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, command or response.
    logic [3:0]    pv, pr;
    logic [AW-1:0] pa [4];
    initial begin
        int   g;
        exp_t e;
        pv = '0;
        pr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (req_ready != 0) begin
                if (gq.size() == 0) unexpected("grant", 64'(req_ready));
                else begin
                    g = gq.pop_front();
                    chk("grant", 64'(req_ready), 64'(4'b0001 << g));
                end
            end else if (gq.size() > 0) begin
                g = gq.pop_front();
                chk("grant", 64'(req_ready), 64'(4'b0001 << g));
            end

            while (cq.size() > 0 && cq[0].due < cyc) begin
                e = cq.pop_front();
                chk("cmd_late_due", 64'(cyc), 64'(e.due));
            end
            if (sram_en) begin
                if (cq.size() == 0) unexpected("sram_cmd", 64'(sram_addr));
                else begin
                    e = cq.pop_front();
                    chk("cmd_due", 64'(cyc), 64'(e.due));
                    chk("cmd_we", 64'(sram_we), 64'(e.we));
                    chk("cmd_addr", 64'(sram_addr), 64'(e.addr));
                    if (e.we) chk("cmd_wdata", 64'(sram_wdata), 64'(e.data));
                end
            end

            while (rq.size() > 0 && rq[0].due < cyc) begin
                e = rq.pop_front();
                chk("rsp_late_due", 64'(cyc), 64'(e.due));
            end
            if (rsp_valid != 0) begin
                if (rq.size() == 0) unexpected("rsp_valid", 64'(rsp_valid));
                else begin
                    e = rq.pop_front();
                    chk("rsp_due", 64'(cyc), 64'(e.due));
                    chk("rsp_valid", 64'(rsp_valid), 64'(3'b001 << e.id));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end

            for (int i = 0; i < 4; i++) begin
                if (!reset && pv[i] && !pr[i])
                    assert (req_valid[i] && addr_of[i] == pa[i])
                    else $error("requester protocol broken on stream %0d", i);
            end
            pv = reset ? 4'b0 : req_valid;
            pr = req_ready;
            for (int i = 0; i < 4; i++) pa[i] = addr_of[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) addr_of[i] = '0;
        mem[20'h00123] = 16'hBEEF;
        mem[20'h00100] = 16'h1111;
        mem[20'h00101] = 16'h2222;
        mem[20'h00102] = 16'h3333;
        mem[20'h00050] = 16'h5050;
        mem[20'h00060] = 16'h6060;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset with two reads in flight; requests during reset are ignored.
        addr_of[0] = 20'h00050;
        addr_of[1] = 20'h00060;
        step(4'b0001, 0, 16'h5050, 1'b0);
        step(4'b0010, 1, 16'h6060, 1'b0);
        step(4'b0000, -1, 16'h0);
        #4 reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_sram_en", 64'(sram_en), 0);
        chk("rst_sram_we", 64'(sram_we), 0);
        chk("rst_sram_addr", 64'(sram_addr), 0);
        chk("rst_sram_wdata", 64'(sram_wdata), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_grant_cnt", 64'(grant_cnt), 0);
        repeat (2) @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        drain();

        // Single ifmap read.
        addr_of[0] = 20'h00123;
        step(4'b0001, 0, 16'hBEEF);
        step(4'b0000, -1, 16'h0);
        drain();

        // Full rotation with cfg_wr_prio=0; each stream drops only after its last grant.
        do_reset();
        addr_of[0] = 20'h00100;
        addr_of[1] = 20'h00101;
        addr_of[2] = 20'h00102;
        addr_of[3] = 20'h00200;
        wr_data    = 16'h5555;
        step(4'b1111, 0, 16'h1111);
        step(4'b1111, 1, 16'h2222);
        step(4'b1111, 2, 16'h3333);
        step(4'b1111, 3, 16'h0);
        step(4'b1111, 0, 16'h1111);
        step(4'b1110, 1, 16'h2222);
        step(4'b1100, 2, 16'h3333);
        step(4'b1000, 3, 16'h0);
        step(4'b0000, -1, 16'h0);
        drain();
        chk("rr_grant_cnt", 64'(grant_cnt), 64'(16'h2222));

        // Write priority: stream 3 wins while valid, then stream 0.
        do_reset();
        cfg_wr_prio = 1'b1;
        addr_of[3]  = 20'h00300;
        wr_data     = 16'h7777;
        step(4'b1001, 3, 16'h0);
        step(4'b1001, 3, 16'h0);
        step(4'b1001, 3, 16'h0);
        step(4'b0001, 0, 16'h1111);
        step(4'b0000, -1, 16'h0);
        drain();
        chk("prio_grant_cnt", 64'(grant_cnt), 64'(16'h3001));
        cfg_wr_prio = 1'b0;

        // Write then read of the same address returns the new data.
        addr_of[3] = 20'h00040;
        addr_of[2] = 20'h00040;
        wr_data    = 16'h1234;
        step(4'b1000, 3, 16'h0);
        step(4'b0100, 2, 16'h1234);
        step(4'b0000, -1, 16'h0);
        drain();

        // Counter saturation and clear priority over a coincident grant.
        do_reset();
        addr_of[1] = 20'h00101;
        for (int n = 0; n < 20; n++) step(4'b0010, 1, 16'h2222);
        step(4'b0000, -1, 16'h0);
        #3;
        chk("sat_grant_cnt1", 64'(grant_cnt[7:4]), 64'(4'hF));
        step(4'b0010, 1, 16'h2222);
        clear_stats = 1'b1;
        step(4'b0000, -1, 16'h0);
        clear_stats = 1'b0;
        #3;
        chk("clr_grant_cnt1", 64'(grant_cnt[7:4]), 0);
        chk("clr_grant_cnt_all", 64'(grant_cnt), 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
